// File: rtl/branch_resolve_stage_if.sv
// Branch-resolve bus: branch-unit input, CDB result port, fetch redirect and
// predictor update, grouped so the stage and its neighbours share one bundle.
interface branch_resolve_stage_if #(
    parameter int XLEN      = 32,
    parameter int ROB_TAG_W = 5
);
    logic                 flush;

    logic                 in_valid;
    logic                 in_ready;
    logic [5:0]           in_func;
    logic [XLEN-1:0]      in_pc;
    logic                 in_cond;
    logic [XLEN-1:0]      in_target_pc;
    logic                 in_pred_taken;
    logic [XLEN-1:0]      in_pred_target;
    logic [ROB_TAG_W-1:0] in_rob_tag;

    logic                 cdb_req;
    logic                 cdb_grant;
    logic [ROB_TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]      cdb_value;
    logic                 cdb_mispredict;
    logic [XLEN-1:0]      cdb_next_pc;

    logic                 redirect_valid;
    logic [XLEN-1:0]      redirect_pc;

    logic                 bp_upd_valid;
    logic [XLEN-1:0]      bp_upd_pc;
    logic                 bp_upd_taken;
    logic [XLEN-1:0]      bp_upd_target;

    modport slave (
        input  flush, in_valid, in_func, in_pc, in_cond, in_target_pc,
               in_pred_taken, in_pred_target, in_rob_tag, cdb_grant,
        output in_ready, cdb_req, cdb_tag, cdb_value, cdb_mispredict, cdb_next_pc,
               redirect_valid, redirect_pc, bp_upd_valid, bp_upd_pc,
               bp_upd_taken, bp_upd_target
    );

    modport master (
        output flush, in_valid, in_func, in_pc, in_cond, in_target_pc,
               in_pred_taken, in_pred_target, in_rob_tag, cdb_grant,
        input  in_ready, cdb_req, cdb_tag, cdb_value, cdb_mispredict, cdb_next_pc,
               redirect_valid, redirect_pc, bp_upd_valid, bp_upd_pc,
               bp_upd_taken, bp_upd_target
    );
endinterface

// File: rtl/branch_resolve_stage.sv
// Resolves branch results against the front-end prediction, queues them for the
// CDB, and on a misprediction pulses redirect/update then stalls until flush.
module branch_resolve_stage #(
    parameter int XLEN      = 32,
    parameter int ROB_TAG_W = 5,
    parameter int DEPTH     = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    branch_resolve_stage_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        ST_RUN,
        ST_WAIT_FLUSH
    } state_t;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] tag;
        logic [XLEN-1:0]      value;
        logic                 mispredict;
        logic [XLEN-1:0]      next_pc;
    } entry_t;

    state_t           r_state;
    state_t           w_state_next;
    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_pop;

    logic [XLEN-1:0]  w_actual_target;
    logic             w_actual_taken;
    logic [XLEN-1:0]  w_pc_plus4;
    logic [XLEN-1:0]  w_next_pc;
    logic             w_mispredict;
    logic [XLEN-1:0]  w_link;
    logic             w_is_branch;
    entry_t           w_entry;

    logic             r_redirect_valid;
    logic [XLEN-1:0]  r_redirect_pc;
    logic             r_bp_upd_valid;
    logic [XLEN-1:0]  r_bp_upd_pc;
    logic             r_bp_upd_taken;
    logic [XLEN-1:0]  r_bp_upd_target;

    // Branch outcome evaluation; register-indirect targets drop bit 0.
    always_comb begin
        w_actual_target = (bus.in_func == 6'h15) ? {bus.in_target_pc[XLEN-1:1], 1'b0}
                                                 : bus.in_target_pc;
        w_actual_taken  = bus.in_cond;
        w_pc_plus4      = bus.in_pc + XLEN'(4);
        w_next_pc       = w_actual_taken ? w_actual_target : w_pc_plus4;
        w_mispredict    = (w_actual_taken != bus.in_pred_taken) ||
                          (w_actual_taken && (w_actual_target != bus.in_pred_target));
        w_link          = ((bus.in_func == 6'h14) || (bus.in_func == 6'h15)) ? w_pc_plus4 : '0;
        w_is_branch     = (bus.in_func >= 6'h0e) && (bus.in_func <= 6'h16);
        w_entry         = '{tag: bus.in_rob_tag, value: w_link,
                            mispredict: w_mispredict, next_pc: w_next_pc};
    end

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    // flush outranks both the incoming branch and the CDB grant.
    assign w_accept = bus.in_valid && w_in_ready && !bus.flush;
    assign w_pop    = !w_empty && bus.cdb_grant && !bus.flush;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_RUN;
        end else begin
            // NOTE: state elements use non-blocking assignment so every register
            // samples pre-edge values regardless of block ordering.
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves
        // a signal unassigned, which would infer a latch.
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_in_ready = !w_full;
                if (w_accept && w_mispredict) begin
                    w_state_next = ST_WAIT_FLUSH;
                end
            end
            ST_WAIT_FLUSH: begin
                w_in_ready = 1'b0;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
        if (bus.flush) begin
            w_state_next = ST_RUN;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            // NOTE: the storage is tiny and the head drives outputs that must read
            // as zero out of reset, so the entries are cleared here as well.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Single-cycle redirect and predictor-update pulses, one cycle after accept.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_bp_upd_valid   <= 1'b0;
            r_bp_upd_pc      <= '0;
            r_bp_upd_taken   <= 1'b0;
            r_bp_upd_target  <= '0;
        end else begin
            r_redirect_valid <= w_accept && w_mispredict;
            r_bp_upd_valid   <= w_accept && w_is_branch;
            if (w_accept && w_mispredict) begin
                r_redirect_pc <= w_next_pc;
            end
            if (w_accept && w_is_branch) begin
                r_bp_upd_pc     <= bus.in_pc;
                r_bp_upd_taken  <= w_actual_taken;
                r_bp_upd_target <= w_actual_target;
            end
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.cdb_req        = !w_empty;
    assign bus.cdb_tag        = r_mem[r_rd_ptr].tag;
    assign bus.cdb_value      = r_mem[r_rd_ptr].value;
    assign bus.cdb_mispredict = r_mem[r_rd_ptr].mispredict;
    assign bus.cdb_next_pc    = r_mem[r_rd_ptr].next_pc;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.bp_upd_valid   = r_bp_upd_valid;
    assign bus.bp_upd_pc      = r_bp_upd_pc;
    assign bus.bp_upd_taken   = r_bp_upd_taken;
    assign bus.bp_upd_target  = r_bp_upd_target;
endmodule

// File: tb/tb_branch_resolve_stage.sv
// Directed bench for branch_resolve_stage: expected CDB results are queued when
// a branch is presented and compared when the stage delivers them under grant.
module tb_branch_resolve_stage;
    localparam int XLEN      = 32;
    localparam int ROB_TAG_W = 5;
    localparam int DEPTH     = 2;

    typedef struct {
        logic [ROB_TAG_W-1:0] tag;
        logic [XLEN-1:0]      value;
        logic                 mispredict;
        logic [XLEN-1:0]      next_pc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    branch_resolve_stage_if #(.XLEN(XLEN), .ROB_TAG_W(ROB_TAG_W)) bus ();

    branch_resolve_stage #(.XLEN(XLEN), .ROB_TAG_W(ROB_TAG_W), .DEPTH(DEPTH)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a branch; exp_rdy is the in_ready level it should meet, and the
    // expected CDB result is queued only when the branch is meant to be kept.
    task automatic send(input logic [5:0] func, input logic [31:0] pc, input logic cond,
                        input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                        input logic [4:0] tag, input logic exp_rdy, input logic keep,
                        input logic [31:0] e_val, input logic e_mis, input logic [31:0] e_npc);
        exp_t e;
        bus.in_valid       = 1'b1;
        bus.in_func        = func;
        bus.in_pc          = pc;
        bus.in_cond        = cond;
        bus.in_target_pc   = tgt;
        bus.in_pred_taken  = pt;
        bus.in_pred_target = ptgt;
        bus.in_rob_tag     = tag;
        chk("in_ready_at_send", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
        if (keep) begin
            e.tag = tag; e.value = e_val; e.mispredict = e_mis; e.next_pc = e_npc;
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard: each granted head is checked against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.cdb_req && bus.cdb_grant) begin
            if (exp_q.size() == 0) begin
                chk("cdb_unexpected_pop", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("cdb_tag",        {27'b0, bus.cdb_tag},        {27'b0, e.tag});
                chk("cdb_value",      bus.cdb_value,               e.value);
                chk("cdb_mispredict", {31'b0, bus.cdb_mispredict}, {31'b0, e.mispredict});
                chk("cdb_next_pc",    bus.cdb_next_pc,             e.next_pc);
            end
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_func = '0; bus.in_pc = '0;
        bus.in_cond = 1'b0; bus.in_target_pc = '0; bus.in_pred_taken = 1'b0;
        bus.in_pred_target = '0; bus.in_rob_tag = '0; bus.cdb_grant = 1'b0;
        step();
        step();
        chk("rst_cdb_req",  {31'b0, bus.cdb_req},        32'd0);
        chk("rst_redirect", {31'b0, bus.redirect_valid}, 32'd0);
        chk("rst_bp_upd",   {31'b0, bus.bp_upd_valid},   32'd0);
        chk("rst_cdb_npc",  bus.cdb_next_pc,             32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", {31'b0, bus.in_ready}, 32'd1);

        // BEQ correctly predicted taken.
        send(6'h0e, 32'h100, 1'b1, 32'h140, 1'b1, 32'h140, 5'd1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h140);
        step();
        bus.in_valid = 1'b0;
        chk("beq_cdb_req",    {31'b0, bus.cdb_req},        32'd1);
        chk("beq_redirect",   {31'b0, bus.redirect_valid}, 32'd0);
        chk("beq_bp_valid",   {31'b0, bus.bp_upd_valid},   32'd1);
        chk("beq_bp_taken",   {31'b0, bus.bp_upd_taken},   32'd1);
        chk("beq_bp_pc",      bus.bp_upd_pc,               32'h100);
        chk("beq_bp_target",  bus.bp_upd_target,           32'h140);
        bus.cdb_grant = 1'b1;
        step();
        bus.cdb_grant = 1'b0;
        chk("beq_drained",    {31'b0, bus.cdb_req},        32'd0);
        chk("beq_bp_pulse",   {31'b0, bus.bp_upd_valid},   32'd0);

        // BNE predicted taken but falls through: redirect and stall.
        send(6'h0f, 32'h200, 1'b0, 32'h280, 1'b1, 32'h280, 5'd2, 1'b1, 1'b1, 32'h0, 1'b1, 32'h204);
        step();
        bus.in_valid = 1'b0;
        chk("bne_redirect",    {31'b0, bus.redirect_valid}, 32'd1);
        chk("bne_redirect_pc", bus.redirect_pc,             32'h204);
        chk("bne_ready_low",   {31'b0, bus.in_ready},       32'd0);
        chk("bne_bp_taken",    {31'b0, bus.bp_upd_taken},   32'd0);
        bus.cdb_grant = 1'b1;
        step();
        bus.cdb_grant = 1'b0;
        chk("bne_redirect_pulse", {31'b0, bus.redirect_valid}, 32'd0);
        send(6'h0e, 32'h240, 1'b0, 32'h0, 1'b0, 32'h0, 5'd9, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        bus.in_valid = 1'b0;
        chk("bne_wait_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("bne_wait_empty", {31'b0, bus.cdb_req},  32'd0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("bne_flush_ready", {31'b0, bus.in_ready}, 32'd1);

        // JALR: bit 0 of target cleared, direction mispredicted, link = pc+4.
        send(6'h15, 32'h300, 1'b1, 32'h1235, 1'b0, 32'h1234, 5'd3, 1'b1, 1'b1, 32'h304, 1'b1, 32'h1234);
        step();
        bus.in_valid = 1'b0;
        chk("jalr_redirect_pc", bus.redirect_pc,   32'h1234);
        chk("jalr_bp_target",   bus.bp_upd_target, 32'h1234);
        bus.cdb_grant = 1'b1;
        step();
        bus.cdb_grant = 1'b0;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;

        // Three back-to-back correct branches with no grant: FIFO fills at two.
        send(6'h14, 32'h400, 1'b1, 32'h500, 1'b1, 32'h500, 5'd4, 1'b1, 1'b1, 32'h404, 1'b0, 32'h500);
        step();
        send(6'h10, 32'h410, 1'b0, 32'h600, 1'b0, 32'h0,   5'd5, 1'b1, 1'b1, 32'h0,   1'b0, 32'h414);
        step();
        send(6'h11, 32'h420, 1'b1, 32'h480, 1'b1, 32'h480, 5'd6, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0);
        step();
        chk("full_ready_held", {31'b0, bus.in_ready}, 32'd0);
        bus.cdb_grant = 1'b1;
        chk("full_no_bypass",  {31'b0, bus.in_ready}, 32'd0);
        step();
        bus.cdb_grant = 1'b0;
        send(6'h11, 32'h420, 1'b1, 32'h480, 1'b1, 32'h480, 5'd6, 1'b1, 1'b1, 32'h0, 1'b0, 32'h480);
        step();
        bus.in_valid = 1'b0;
        chk("refill_full", {31'b0, bus.in_ready}, 32'd0);
        bus.cdb_grant = 1'b1;
        step();
        step();
        bus.cdb_grant = 1'b0;
        chk("order_drained", {31'b0, bus.cdb_req}, 32'd0);

        // Mispredict presented together with flush: discarded, FIFO emptied.
        send(6'h12, 32'h700, 1'b0, 32'h0, 1'b0, 32'h0, 5'd7, 1'b1, 1'b1, 32'h0, 1'b0, 32'h704);
        step();
        send(6'h13, 32'h710, 1'b1, 32'h720, 1'b0, 32'h0, 5'd8, 1'b1, 1'b0, 32'h0, 1'b1, 32'h720);
        bus.flush = 1'b1;
        exp_q.delete();
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_redirect", {31'b0, bus.redirect_valid}, 32'd0);
        chk("fl_bp_upd",   {31'b0, bus.bp_upd_valid},   32'd0);
        chk("fl_empty",    {31'b0, bus.cdb_req},        32'd0);
        chk("fl_ready",    {31'b0, bus.in_ready},       32'd1);

        // Reset while full and waiting for flush.
        send(6'h0e, 32'h800, 1'b1, 32'h840, 1'b1, 32'h840, 5'd9,  1'b1, 1'b1, 32'h0, 1'b0, 32'h840);
        step();
        send(6'h0f, 32'h900, 1'b1, 32'h980, 1'b0, 32'h0,   5'd10, 1'b1, 1'b1, 32'h0, 1'b1, 32'h980);
        step();
        chk("pre_rst_redirect", {31'b0, bus.redirect_valid}, 32'd1);
        chk("pre_rst_ready",    {31'b0, bus.in_ready},       32'd0);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_cdb_req",   {31'b0, bus.cdb_req},        32'd0);
        chk("arst_redirect",  {31'b0, bus.redirect_valid}, 32'd0);
        chk("arst_redir_pc",  bus.redirect_pc,             32'd0);
        chk("arst_bp_upd",    {31'b0, bus.bp_upd_valid},   32'd0);
        chk("arst_bp_target", bus.bp_upd_target,           32'd0);
        chk("arst_cdb_tag",   {27'b0, bus.cdb_tag},        32'd0);
        chk("arst_cdb_value", bus.cdb_value,               32'd0);
        step();
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("rel_ready",   {31'b0, bus.in_ready}, 32'd1);
        chk("rel_cdb_req", {31'b0, bus.cdb_req},  32'd0);

        // pc+4 wraps; func 0x16 carries no link value.
        send(6'h14, 32'hFFFF_FFFC, 1'b0, 32'h10, 1'b0, 32'h10, 5'd12, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0);
        step();
        send(6'h16, 32'hA00, 1'b1, 32'hA81, 1'b1, 32'hA81, 5'd11, 1'b1, 1'b1, 32'h0, 1'b0, 32'hA81);
        bus.cdb_grant = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("j16_bp_target", bus.bp_upd_target, 32'hA81);
        step();
        bus.cdb_grant = 1'b0;
        chk("final_empty", {31'b0, bus.cdb_req}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
